// File: rtl/alu_seq_pkg.sv
// Shared types and widths for the ALU operand sequencer.
package alu_seq_pkg;

  localparam int OPERAND_W = 4;
  localparam int RESULT_W  = 20;
  localparam int SETTLE_W  = 4;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD_A  = 3'd1,
    ST_LOAD_B  = 3'd2,
    ST_COMPUTE = 3'd3,
    ST_SHOW    = 3'd4
  } seq_state_e;

endpackage

// File: rtl/alu_op_sequencer_btn_sync_edge.sv
// Raw push-button conditioning: 2-flop synchronizer followed by a registered
// rising-edge detector that emits a single-cycle pulse per press.
module btn_sync_edge
  import alu_seq_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic pulse
);

  logic sync_1_r;
  logic sync_2_r;
  logic prev_r;
  logic pulse_r;

  // Synchronizer chain and edge-detect pulse register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_1_r <= 1'b0;
      sync_2_r <= 1'b0;
      prev_r   <= 1'b0;
      pulse_r  <= 1'b0;
    end else begin
      sync_1_r <= btn;
      sync_2_r <= sync_1_r;
      prev_r   <= sync_2_r;
      pulse_r  <= sync_2_r & ~prev_r;
    end
  end

  assign pulse = pulse_r;

endmodule

// File: rtl/alu_op_sequencer.sv
// Button-stepped operand entry, settle wait and result capture for the mini ALU.
// Optional display blinking in SHOW when ALU_SEQ_BLINK_EN is defined.
module alu_op_sequencer
  import alu_seq_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2,
  parameter int BLINK_DIV     = 25_000_000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [OPERAND_W-1:0] value_sw,
  input  logic                 mode_sw,
  input  logic                 enter_btn,
  input  logic                 cancel_btn,
  input  logic [RESULT_W-1:0]  alu_result,
  output logic [OPERAND_W-1:0] operand_1,
  output logic [OPERAND_W-1:0] operand_2,
  output logic                 mode,
  output logic [RESULT_W-1:0]  result_q,
  output logic                 display_on,
  output logic                 busy,
  output logic [2:0]           state_o
);

  localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_CYCLES - 1);

  logic                 enter_p_s;
  logic                 cancel_p_s;
  seq_state_e           state_r;
  seq_state_e           next_state_s;
  logic [SETTLE_W-1:0]  settle_cnt_r;
  logic                 settle_done_s;
  logic [OPERAND_W-1:0] operand_1_r;
  logic [OPERAND_W-1:0] operand_2_r;
  logic                 mode_r;
  logic [RESULT_W-1:0]  result_r;
  logic                 busy_r;

  btn_sync_edge u_enter_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .btn   (enter_btn),
    .pulse (enter_p_s)
  );

  btn_sync_edge u_cancel_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .btn   (cancel_btn),
    .pulse (cancel_p_s)
  );

  assign settle_done_s = (settle_cnt_r == SETTLE_LAST);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic; cancel overrides any simultaneous enter.
  always_comb begin
    next_state_s = state_r;
    if (cancel_p_s) begin
      next_state_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE:    if (enter_p_s) next_state_s = ST_LOAD_A;  else next_state_s = ST_IDLE;
        ST_LOAD_A:  if (enter_p_s) next_state_s = ST_LOAD_B;  else next_state_s = ST_LOAD_A;
        ST_LOAD_B:  if (enter_p_s) next_state_s = ST_COMPUTE; else next_state_s = ST_LOAD_B;
        ST_COMPUTE: if (settle_done_s) next_state_s = ST_SHOW; else next_state_s = ST_COMPUTE;
        ST_SHOW:    if (enter_p_s) next_state_s = ST_LOAD_A;  else next_state_s = ST_SHOW;
        default:    next_state_s = ST_IDLE;
      endcase
    end
  end

  // Operand tracking, settle counter and result capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      operand_1_r  <= {OPERAND_W{1'b0}};
      operand_2_r  <= {OPERAND_W{1'b0}};
      mode_r       <= 1'b0;
      result_r     <= {RESULT_W{1'b0}};
      settle_cnt_r <= {SETTLE_W{1'b0}};
    end else if (cancel_p_s) begin
      operand_1_r  <= {OPERAND_W{1'b0}};
      operand_2_r  <= {OPERAND_W{1'b0}};
      mode_r       <= 1'b0;
      result_r     <= {RESULT_W{1'b0}};
      settle_cnt_r <= {SETTLE_W{1'b0}};
    end else begin
      case (state_r)
        ST_LOAD_A: begin
          operand_1_r <= value_sw;
        end
        ST_LOAD_B: begin
          operand_2_r  <= value_sw;
          mode_r       <= mode_sw;
          settle_cnt_r <= {SETTLE_W{1'b0}};
        end
        ST_COMPUTE: begin
          if (settle_done_s) begin
            result_r     <= alu_result;
            settle_cnt_r <= {SETTLE_W{1'b0}};
          end else begin
            settle_cnt_r <= settle_cnt_r + 4'd1;
          end
        end
        default: begin
          settle_cnt_r <= {SETTLE_W{1'b0}};
        end
      endcase
    end
  end

  // Busy flag registered from the upcoming state so it aligns with COMPUTE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_r <= 1'b0;
    end else begin
      busy_r <= (next_state_s == ST_COMPUTE);
    end
  end

`ifdef ALU_SEQ_BLINK_EN
  localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);

  logic [BLINK_W-1:0] blink_cnt_r;
  logic               blink_r;

  // Blink divider: restarts lit on SHOW entry, dark outside SHOW.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt_r <= {BLINK_W{1'b0}};
      blink_r     <= 1'b0;
    end else if (next_state_s != ST_SHOW) begin
      blink_cnt_r <= {BLINK_W{1'b0}};
      blink_r     <= 1'b0;
    end else if (state_r != ST_SHOW) begin
      blink_cnt_r <= {BLINK_W{1'b0}};
      blink_r     <= 1'b1;
    end else if (blink_cnt_r == BLINK_LAST) begin
      blink_cnt_r <= {BLINK_W{1'b0}};
      blink_r     <= ~blink_r;
    end else begin
      blink_cnt_r <= blink_cnt_r + BLINK_W'(1);
    end
  end

  assign display_on = blink_r;
`else
  logic display_r;

  // Steady display enable throughout SHOW.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      display_r <= 1'b0;
    end else begin
      display_r <= (next_state_s == ST_SHOW);
    end
  end

  assign display_on = display_r;
`endif

  assign operand_1 = operand_1_r;
  assign operand_2 = operand_2_r;
  assign mode      = mode_r;
  assign result_q  = result_r;
  assign busy      = busy_r;
  assign state_o   = state_r;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed self-checking bench for alu_op_sequencer (SETTLE_CYCLES=2, BLINK_DIV=4).
module tb_alu_op_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  value_sw;
  logic        mode_sw;
  logic        enter_btn;
  logic        cancel_btn;
  logic [19:0] alu_result;
  logic [3:0]  operand_1;
  logic [3:0]  operand_2;
  logic        mode;
  logic [19:0] result_q;
  logic        display_on;
  logic        busy;
  logic [2:0]  state_o;

  int n_checks = 0;
  int n_errors = 0;
  int busy_cnt = 0;
  int show_idx = 0;
  logic show_hist [16];

  always #5 clk = ~clk;

  // Mini ALU stand-in: mode 1 multiplies, mode 0 adds.
  assign alu_result = mode ? ({16'd0, operand_1} * {16'd0, operand_2})
                           : ({16'd0, operand_1} + {16'd0, operand_2});

  alu_op_sequencer #(.SETTLE_CYCLES(2), .BLINK_DIV(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .value_sw   (value_sw),
    .mode_sw    (mode_sw),
    .enter_btn  (enter_btn),
    .cancel_btn (cancel_btn),
    .alu_result (alu_result),
    .operand_1  (operand_1),
    .operand_2  (operand_2),
    .mode       (mode),
    .result_q   (result_q),
    .display_on (display_on),
    .busy       (busy),
    .state_o    (state_o)
  );

  always @(negedge clk) begin
    if (busy === 1'b1) busy_cnt++;
    if (state_o === 3'd4) begin
      if (show_idx < 16) show_hist[show_idx] = display_on;
      show_idx++;
    end else begin
      show_idx = 0;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_cleared(input string tag);
    check_eq({tag, " state"},   32'(state_o),    32'd0);
    check_eq({tag, " op1"},     32'(operand_1),  32'd0);
    check_eq({tag, " op2"},     32'(operand_2),  32'd0);
    check_eq({tag, " mode"},    32'(mode),       32'd0);
    check_eq({tag, " result"},  32'(result_q),   32'd0);
    check_eq({tag, " display"}, 32'(display_on), 32'd0);
    check_eq({tag, " busy"},    32'(busy),       32'd0);
  endtask

  task automatic press(input logic do_enter, input logic do_cancel);
    @(negedge clk);
    enter_btn  = do_enter;
    cancel_btn = do_cancel;
    repeat (5) @(negedge clk);
    enter_btn  = 1'b0;
    cancel_btn = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; value_sw = 4'h0; mode_sw = 1'b0;
    enter_btn = 1'b0; cancel_btn = 1'b0;
    repeat (3) @(negedge clk);
    check_cleared("rst_low");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check_cleared("rst_rel");

    // Full flow: A=5, B=3, mode=1 -> 15
    press(1'b1, 1'b0);
    check_eq("idle_to_a", 32'(state_o), 32'd1);
    value_sw = 4'h5;
    press(1'b1, 1'b0);
    check_eq("a_to_b", 32'(state_o), 32'd2);
    check_eq("op1_frozen", 32'(operand_1), 32'h5);
    value_sw = 4'h3; mode_sw = 1'b1;
    busy_cnt = 0;
    press(1'b1, 1'b0);
    check_eq("show_state", 32'(state_o), 32'd4);
    check_eq("busy_len", 32'(busy_cnt), 32'd2);
    check_eq("flow_op1", 32'(operand_1), 32'h5);
    check_eq("flow_op2", 32'(operand_2), 32'h3);
    check_eq("flow_mode", 32'(mode), 32'd1);
    check_eq("flow_result", 32'(result_q), 32'h0000F);
    check_eq("show_busy", 32'(busy), 32'd0);
    repeat (6) @(negedge clk);
    for (int i = 0; i < 10; i++) begin
`ifdef ALU_SEQ_BLINK_EN
      check_eq($sformatf("disp_%0d", i), 32'(show_hist[i]), ((i / 4) % 2 == 0) ? 32'd1 : 32'd0);
`else
      check_eq($sformatf("disp_%0d", i), 32'(show_hist[i]), 32'd1);
`endif
    end

    // New calculation from SHOW keeps the old result
    value_sw = 4'h9;
    press(1'b1, 1'b0);
    check_eq("show_to_a", 32'(state_o), 32'd1);
    check_eq("track_9", 32'(operand_1), 32'h9);
    check_eq("keep_result", 32'(result_q), 32'h0000F);
    check_eq("a_display", 32'(display_on), 32'd0);

    // Held button: exactly one advance
    @(negedge clk);
    enter_btn = 1'b1;
    repeat (100) @(negedge clk);
    check_eq("held_state", 32'(state_o), 32'd2);
    enter_btn = 1'b0;
    repeat (5) @(negedge clk);
    check_eq("held_release", 32'(state_o), 32'd2);
    check_eq("held_op1", 32'(operand_1), 32'h9);

    // Reset in the middle of COMPUTE
    value_sw = 4'h2; mode_sw = 1'b0;
    @(negedge clk);
    enter_btn = 1'b1;
    for (int i = 0; i < 20 && state_o !== 3'd3; i++) @(negedge clk);
    check_eq("reach_compute", 32'(state_o), 32'd3);
    rst_n = 1'b0;
    #1;
    check_cleared("rst_mid");
    enter_btn = 1'b0;
    repeat (3) @(negedge clk);
    check_cleared("rst_mid_hold");
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check_cleared("rst_mid_rel");

    // Second flow: 7 + 1 = 8, then cancel+enter together in LOAD_B
    press(1'b1, 1'b0);
    value_sw = 4'h7;
    press(1'b1, 1'b0);
    value_sw = 4'h1;
    press(1'b1, 1'b0);
    check_eq("flow2_state", 32'(state_o), 32'd4);
    check_eq("flow2_result", 32'(result_q), 32'h00008);
    value_sw = 4'h4;
    press(1'b1, 1'b0);
    press(1'b1, 1'b0);
    check_eq("flow2_b", 32'(state_o), 32'd2);
    check_eq("flow2_op1", 32'(operand_1), 32'h4);
    press(1'b1, 1'b1);
    check_cleared("cancel_wins");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
